// File: rtl/wb_trace_port_if.sv
// Writeback capture inputs and the trace record stream of wb_trace_port.
// The master modport is the trace writer; the slave modport is the pipeline/reader side.
interface wb_trace_port_if #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 3,
    parameter int TS_W   = 8
);
    logic                        wb_we;
    logic [RA_W-1:0]             wb_dest;
    logic [DATA_W-1:0]           wb_result;
    logic                        trace_valid;
    logic [TS_W+RA_W+DATA_W-1:0] trace_data;
    logic                        trace_ready;

    modport master (
        input  wb_we, wb_dest, wb_result, trace_ready,
        output trace_valid, trace_data
    );

    modport slave (
        output wb_we, wb_dest, wb_result, trace_ready,
        input  trace_valid, trace_data
    );
endinterface

// File: rtl/wb_trace_port.sv
// MEM/WB writeback trace writer: triggered capture of {timestamp, dest, result}
// records into a show-ahead FIFO drained over a valid/ready stream.
module wb_trace_port #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 3,
    parameter int TS_W   = 8,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 trace_en,
    input  logic                 trig_any,
    input  logic [RA_W-1:0]      trig_reg,
    wb_trace_port_if.master      tp,
    output logic                 overflow,
    output logic [7:0]           drop_cnt,
    output logic [1:0]           state_o
);
    localparam int REC_W = TS_W + RA_W + DATA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W:0]     count;
    logic [TS_W-1:0]    ts;
    logic               event_w, push, pop, arm, empty, full, accept, drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign event_w = ce && tp.wb_we;
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop     = !empty && tp.trace_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign accept  = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign tp.trace_valid = !empty;
    assign tp.trace_data  = mem[rd_ptr];
    assign state_o        = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stopping capture wins over any event or trigger in the same cycle.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        arm       = 1'b0;
        unique case (state)
            IDLE: begin
                if (trace_en) begin
                    state_nxt = ARMED;
                    arm       = 1'b1;
                end
            end
            ARMED: begin
                if (!trace_en) begin
                    state_nxt = DRAIN;
                end else if (event_w && (trig_any || tp.wb_dest == trig_reg)) begin
                    state_nxt = CAPTURE;
                    push      = 1'b1;
                end
            end
            CAPTURE: begin
                if (!trace_en) state_nxt = DRAIN;
                else           push      = event_w;
            end
            DRAIN: begin
                if (empty || (count == CNT_ONE && pop)) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else if (arm) begin
            ts <= '0;
        end else if (ce && (state == ARMED || state == CAPTURE)) begin
            ts <= ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (arm) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    // Storage is cleared on reset so a discarded trace never resurfaces on trace_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {ts, tp.wb_dest, tp.wb_result};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trace_port.sv
// Bench for wb_trace_port: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_trace_port;
    localparam int DATA_W = 8;
    localparam int RA_W   = 3;
    localparam int TS_W   = 8;
    localparam int DEPTH  = 4;
    localparam int REC_W  = TS_W + RA_W + DATA_W;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ce = 1'b0;
    logic            trace_en = 1'b0;
    logic            trig_any = 1'b0;
    logic [RA_W-1:0] trig_reg = '0;
    logic            overflow;
    logic [7:0]      drop_cnt;
    logic [1:0]      state_o;

    int checks = 0;
    int failures = 0;

    wb_trace_port_if #(.DATA_W(DATA_W), .RA_W(RA_W), .TS_W(TS_W)) bus ();

    wb_trace_port #(.DATA_W(DATA_W), .RA_W(RA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .trace_en (trace_en),
        .trig_any (trig_any),
        .trig_reg (trig_reg),
        .tp       (bus),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a record queue plus the mode/timestamp/drop bookkeeping.
    logic [REC_W-1:0] m_q[$];
    int               m_state;
    logic [TS_W-1:0]  m_ts;
    logic             m_ovf;
    int               m_drop;
    bit               m_ev, m_pop, m_push;
    int               m_ns;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_state = 0;
            m_ts    = '0;
            m_ovf   = 1'b0;
            m_drop  = 0;
        end else begin
            m_ev   = ce && bus.wb_we;
            m_pop  = (m_q.size() > 0) && bus.trace_ready;
            m_push = 1'b0;
            m_ns   = m_state;
            case (m_state)
                0: if (trace_en) m_ns = 1;
                1: if (!trace_en) m_ns = 3;
                   else if (m_ev && (trig_any || bus.wb_dest == trig_reg)) begin
                       m_ns = 2; m_push = 1'b1;
                   end
                2: if (!trace_en) m_ns = 3;
                   else m_push = m_ev;
                default: if (m_q.size() == 0 || (m_q.size() == 1 && m_pop)) m_ns = 0;
            endcase
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({m_ts, bus.wb_dest, bus.wb_result});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if ((m_state == 1 || m_state == 2) && ce) m_ts = m_ts + 8'd1;
            if (m_state == 0 && trace_en) begin
                m_ts = '0; m_ovf = 1'b0; m_drop = 0;
            end
            m_state = m_ns;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("m_valid", 32'(bus.trace_valid), 32'(m_q.size() > 0));
            chk("m_state", 32'(state_o), 32'(m_state));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (m_q.size() > 0) chk("m_data", 32'(bus.trace_data), 32'(m_q[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic we, input logic [RA_W-1:0] d, input logic [DATA_W-1:0] r);
        bus.wb_we     = we;
        bus.wb_dest   = d;
        bus.wb_result = r;
    endtask

    logic [TS_W-1:0] t1;

    initial begin
        wb(1'b0, '0, '0);
        bus.trace_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.trace_valid), 32'd0);
        chk("rst_data", 32'(bus.trace_data), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        cyc();
        reset = 1'b1;

        // Basic capture
        trace_en = 1'b1; trig_any = 1'b1; bus.trace_ready = 1'b1; ce = 1'b1;
        cyc();
        chk("basic_armed", 32'(state_o), 32'd1);
        cyc(); cyc();
        wb(1'b1, 3'd2, 8'h15); cyc();
        chk("basic_state2", 32'(state_o), 32'd2);
        chk("basic_rec1", 32'(bus.trace_data), 32'h1215);
        wb(1'b1, 3'd5, 8'hA0); cyc();
        chk("basic_rec2", 32'(bus.trace_data), 32'h1DA0);
        wb(1'b0, '0, '0); cyc();
        chk("basic_empty", 32'(bus.trace_valid), 32'd0);
        trace_en = 1'b0; cyc(); cyc();

        // Register trigger
        trace_en = 1'b1; trig_any = 1'b0; trig_reg = 3'd3; cyc();
        wb(1'b1, 3'd1, 8'h11); cyc();
        chk("trig_r1_state", 32'(state_o), 32'd1);
        chk("trig_r1_valid", 32'(bus.trace_valid), 32'd0);
        wb(1'b1, 3'd3, 8'h33); cyc();
        chk("trig_r3_state", 32'(state_o), 32'd2);
        chk("trig_r3_rec", 32'(bus.trace_data[10:0]), 32'h333);
        wb(1'b1, 3'd1, 8'h44); cyc();
        chk("trig_r1b_rec", 32'(bus.trace_data[10:0]), 32'h144);
        wb(1'b0, '0, '0); trace_en = 1'b0; cyc(); cyc();

        // Overflow with backpressure
        trace_en = 1'b1; trig_any = 1'b1; bus.trace_ready = 1'b0; cyc();
        for (int i = 0; i < 6; i++) begin
            wb(1'b1, 3'(i), 8'(8'h40 + i)); cyc();
        end
        wb(1'b0, '0, '0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", 32'(bus.trace_data[7:0]), 32'(8'h40 + i));
            cyc();
        end
        chk("ovf_drained", 32'(bus.trace_valid), 32'd0);

        // Full FIFO with push and pop on the same edge
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb(1'b1, 3'd6, 8'(8'h50 + i)); cyc();
        end
        wb(1'b1, 3'd7, 8'h60); bus.trace_ready = 1'b1; cyc();
        wb(1'b0, '0, '0); bus.trace_ready = 1'b0;
        chk("full_pp_drop", 32'(drop_cnt), 32'd2);
        chk("full_pp_head", 32'(bus.trace_data[7:0]), 32'h51);

        // Stop and drain
        bus.trace_ready = 1'b1; cyc(); bus.trace_ready = 1'b0;
        wb(1'b1, 3'd7, 8'h77); trace_en = 1'b0; cyc();
        wb(1'b0, '0, '0);
        chk("stop_state", 32'(state_o), 32'd3);
        bus.trace_ready = 1'b1;
        cyc(); cyc();
        chk("drain_mid_state", 32'(state_o), 32'd3);
        chk("drain_last_head", 32'(bus.trace_data[7:0]), 32'h60);
        cyc();
        chk("drain_done_state", 32'(state_o), 32'd0);
        chk("drain_done_valid", 32'(bus.trace_valid), 32'd0);
        trace_en = 1'b1; cyc();
        chk("rearm_overflow", 32'(overflow), 32'd0);
        chk("rearm_drop", 32'(drop_cnt), 32'd0);

        // Async reset mid-drain
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb(1'b1, 3'd4, 8'(8'h90 + i)); cyc();
        end
        wb(1'b0, '0, '0); trace_en = 1'b0; cyc();
        chk("pre_rst_state", 32'(state_o), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.trace_valid), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_data", 32'(bus.trace_data), 32'd0);
        cyc();
        reset = 1'b1;

        // Timestamp wrap: 256 ce-cycles between two events
        trace_en = 1'b1; trig_any = 1'b1; bus.trace_ready = 1'b1; ce = 1'b1; cyc();
        wb(1'b1, 3'd4, 8'hAB); cyc();
        wb(1'b0, '0, '0);
        t1 = bus.trace_data[REC_W-1 -: TS_W];
        chk("wrap_first_ts", 32'(t1), 32'd0);
        for (int k = 0; k < 255; k++) begin
            if (k % 64 == 0) begin
                ce = 1'b0; cyc(); ce = 1'b1;
            end
            cyc();
        end
        wb(1'b1, 3'd5, 8'hCD); cyc();
        wb(1'b0, '0, '0);
        chk("wrap_valid", 32'(bus.trace_valid), 32'd1);
        chk("wrap_ts_equal", 32'(bus.trace_data[REC_W-1 -: TS_W]), 32'(t1));
        trace_en = 1'b0; cyc(); cyc();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 0) begin
                trig_any = 1'($urandom_range(0, 1));
                trig_reg = 3'($urandom);
            end
            trace_en        = ($urandom_range(0, 99) < 93);
            ce              = ($urandom_range(0, 9) < 8);
            bus.trace_ready = ($urandom_range(0, 9) < 5);
            wb(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                #1;
                chk("rnd_arst_valid", 32'(bus.trace_valid), 32'd0);
                chk("rnd_arst_state", 32'(state_o), 32'd0);
                cyc();
                reset = 1'b1;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
